// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and default widths for the AR tag allocator.
package rob_pkg;

  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int DEF_TAG_WIDTH  = 4;
  localparam int NUM_TAGS       = 2 ** DEF_TAG_WIDTH;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_LEN_WIDTH-1:0]  len;
  } ar_req_t;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]  id;
    logic [DEF_LEN_WIDTH-1:0] len;
  } tag_entry_t;

endpackage

// File: rtl/tag_free_pool.sv
// rtl/tag_free_pool.sv - busy vector, lowest-free-tag encoder, release checking and in-use count.
module tag_free_pool
  import rob_pkg::*;
#(
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_alloc,
  input  logic                 i_rel_valid,
  input  logic [TAG_WIDTH-1:0] i_rel_tag,
  output logic                 o_tag_avail,
  output logic [TAG_WIDTH-1:0] o_free_tag,
  output logic [TAG_WIDTH:0]   o_busy_cnt,
  output logic                 o_err_rel
);

  localparam int NTAGS = 2 ** TAG_WIDTH;

  logic [NTAGS-1:0]     r_busy;
  logic [TAG_WIDTH:0]   r_busy_cnt;
  logic                 r_err_rel;
  logic [TAG_WIDTH-1:0] w_free_tag;
  logic                 w_rel_ok;

  // Scan downward so the last hit, and thus the winner, is the lowest free index.
  always_comb begin
    w_free_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_tag = TAG_WIDTH'(i);
    end
  end

  assign w_rel_ok = i_rel_valid & r_busy[i_rel_tag];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_err_rel  <= 1'b0;
    end else begin
      if (w_rel_ok) r_busy[i_rel_tag] <= 1'b0;
      if (i_alloc)  r_busy[w_free_tag] <= 1'b1;
      r_busy_cnt <= r_busy_cnt + (TAG_WIDTH+1)'(i_alloc) - (TAG_WIDTH+1)'(w_rel_ok);
      if (i_rel_valid && !r_busy[i_rel_tag]) r_err_rel <= 1'b1;
    end
  end

  assign o_tag_avail = ~&r_busy;
  assign o_free_tag  = w_free_tag;
  assign o_busy_cnt  = r_busy_cnt;
  assign o_err_rel   = r_err_rel;

endmodule

// File: rtl/ar_tag_allocator.sv
// rtl/ar_tag_allocator.sv - buffers AR requests, renames their IDs to free ROB tags, records ID/LEN per tag.
module ar_tag_allocator
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_in_valid,
  output logic                  ar_in_ready,
  input  logic [ID_WIDTH-1:0]   ar_in_id,
  input  logic [ADDR_WIDTH-1:0] ar_in_addr,
  input  logic [LEN_WIDTH-1:0]  ar_in_len,
  output logic                  ar_out_valid,
  input  logic                  ar_out_ready,
  output logic [TAG_WIDTH-1:0]  ar_out_id,
  output logic [ADDR_WIDTH-1:0] ar_out_addr,
  output logic [LEN_WIDTH-1:0]  ar_out_len,
  output logic                  alloc_valid,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  output logic [ID_WIDTH-1:0]   alloc_id,
  input  logic                  rel_valid,
  input  logic [TAG_WIDTH-1:0]  rel_tag,
  input  logic [TAG_WIDTH-1:0]  lk_tag,
  output logic [ID_WIDTH-1:0]   lk_id,
  output logic [LEN_WIDTH-1:0]  lk_len,
  output logic [TAG_WIDTH:0]    busy_cnt,
  output logic                  err_rel
);

  localparam int NTAGS = 2 ** TAG_WIDTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  ar_req_t              r_fifo [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  tag_entry_t           r_table [NTAGS];
  logic                 r_out_valid;
  logic [TAG_WIDTH-1:0] r_out_tag;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [LEN_WIDTH-1:0] r_out_len;
  logic                 r_alloc_valid;
  logic [TAG_WIDTH-1:0] r_alloc_tag;
  logic [ID_WIDTH-1:0]  r_alloc_id;

  ar_req_t              w_head;
  logic                 w_push, w_load, w_full, w_tag_avail;
  logic [TAG_WIDTH-1:0] w_free_tag;

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_full      = (r_count == CW'(DEPTH));
  assign ar_in_ready = ~w_full;
  assign w_push      = ar_in_valid & ~w_full;
  assign w_load      = (r_count != '0) & w_tag_avail & (~r_out_valid | ar_out_ready);

  tag_free_pool #(.TAG_WIDTH(TAG_WIDTH)) u_pool (
    .clk         (clk),
    .rst         (rst),
    .i_alloc     (w_load),
    .i_rel_valid (rel_valid),
    .i_rel_tag   (rel_tag),
    .o_tag_avail (w_tag_avail),
    .o_free_tag  (w_free_tag),
    .o_busy_cnt  (busy_cnt),
    .o_err_rel   (err_rel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_load);
    end
  end

  // Payload storage carries no reset; validity lives in the pointers and busy bits.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{id: ar_in_id, addr: ar_in_addr, len: ar_in_len};
    if (w_load) r_table[w_free_tag] <= '{id: w_head.id, len: w_head.len};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_tag     <= '0;
      r_out_addr    <= '0;
      r_out_len     <= '0;
      r_alloc_valid <= 1'b0;
      r_alloc_tag   <= '0;
      r_alloc_id    <= '0;
    end else begin
      r_alloc_valid <= w_load;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_tag   <= w_free_tag;
        r_out_addr  <= w_head.addr;
        r_out_len   <= w_head.len;
        r_alloc_tag <= w_free_tag;
        r_alloc_id  <= w_head.id;
      end else if (ar_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign ar_out_valid = r_out_valid;
  assign ar_out_id    = r_out_tag;
  assign ar_out_addr  = r_out_addr;
  assign ar_out_len   = r_out_len;
  assign alloc_valid  = r_alloc_valid;
  assign alloc_tag    = r_alloc_tag;
  assign alloc_id     = r_alloc_id;
  assign lk_id        = r_table[lk_tag].id;
  assign lk_len       = r_table[lk_tag].len;

endmodule

// File: tb/tb_ar_tag_allocator.sv
// tb/tb_ar_tag_allocator.sv - directed table vectors plus hand sequences for ar_tag_allocator.
module tb_ar_tag_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_in_valid, ar_in_ready;
  logic [3:0]  ar_in_id;
  logic [31:0] ar_in_addr;
  logic [7:0]  ar_in_len;
  logic        ar_out_valid, ar_out_ready;
  logic [3:0]  ar_out_id;
  logic [31:0] ar_out_addr;
  logic [7:0]  ar_out_len;
  logic        alloc_valid;
  logic [3:0]  alloc_tag, alloc_id;
  logic        rel_valid;
  logic [3:0]  rel_tag, lk_tag, lk_id;
  logic [7:0]  lk_len;
  logic [4:0]  busy_cnt;
  logic        err_rel;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ar_tag_allocator dut (
    .clk(clk), .rst(rst),
    .ar_in_valid(ar_in_valid), .ar_in_ready(ar_in_ready), .ar_in_id(ar_in_id),
    .ar_in_addr(ar_in_addr), .ar_in_len(ar_in_len),
    .ar_out_valid(ar_out_valid), .ar_out_ready(ar_out_ready), .ar_out_id(ar_out_id),
    .ar_out_addr(ar_out_addr), .ar_out_len(ar_out_len),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_id(alloc_id),
    .rel_valid(rel_valid), .rel_tag(rel_tag),
    .lk_tag(lk_tag), .lk_id(lk_id), .lk_len(lk_len),
    .busy_cnt(busy_cnt), .err_rel(err_rel)
  );

  typedef struct {
    logic        in_valid;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        rel_v;
    logic [3:0]  rel_t;
    logic        e_out_valid;
    logic [3:0]  e_out_id;
    logic [31:0] e_out_addr;
    logic [7:0]  e_out_len;
    logic        e_alloc;
    logic [3:0]  e_alloc_id;
    logic [4:0]  e_busy;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic iv, logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                              logic rv, logic [3:0] rt, logic eov, logic [3:0] eoid,
                              logic [31:0] eoaddr, logic [7:0] eolen, logic eal,
                              logic [3:0] eaid, logic [4:0] ebusy);
    vec_t v;
    v.in_valid = iv; v.id = id; v.addr = addr; v.len = len; v.rel_v = rv; v.rel_t = rt;
    v.e_out_valid = eov; v.e_out_id = eoid; v.e_out_addr = eoaddr; v.e_out_len = eolen;
    v.e_alloc = eal; v.e_alloc_id = eaid; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    ar_in_valid = v; ar_in_id = id; ar_in_addr = a; ar_in_len = l;
  endtask

  initial begin
    int exp_tag;
    rst = 1'b1; ar_out_ready = 1'b1; rel_valid = 1'b0; rel_tag = '0; lk_tag = '0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset in_ready", 32'(ar_in_ready), 1);
    chk("reset out_valid", 32'(ar_out_valid), 0);
    chk("reset alloc_valid", 32'(alloc_valid), 0);
    chk("reset busy_cnt", 32'(busy_cnt), 0);
    chk("reset err_rel", 32'(err_rel), 0);

    //            iv id addr      len rv rt  eov eoid eoaddr   eolen eal eaid busy
    vecs[0]  = mk(1, 5, 32'h1000, 3, 0, 0,  0, 0, 0,        0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,        0, 0, 0,  1, 0, 32'h1000, 3, 1, 5, 1);
    vecs[2]  = mk(0, 0, 0,        0, 0, 0,  0, 0, 0,        0, 0, 0, 1);
    vecs[3]  = mk(1, 1, 32'h2000, 0, 0, 0,  0, 0, 0,        0, 0, 0, 1);
    vecs[4]  = mk(1, 2, 32'h3000, 1, 0, 0,  1, 1, 32'h2000, 0, 1, 1, 2);
    vecs[5]  = mk(0, 0, 0,        0, 0, 0,  1, 2, 32'h3000, 1, 1, 2, 3);
    vecs[6]  = mk(0, 0, 0,        0, 0, 0,  0, 0, 0,        0, 0, 0, 3);
    vecs[7]  = mk(0, 0, 0,        0, 1, 1,  0, 0, 0,        0, 0, 0, 2);
    vecs[8]  = mk(1, 7, 32'h4000, 2, 0, 0,  0, 0, 0,        0, 0, 0, 2);
    vecs[9]  = mk(0, 0, 0,        0, 0, 0,  1, 1, 32'h4000, 2, 1, 7, 3);
    vecs[10] = mk(0, 0, 0,        0, 0, 0,  0, 0, 0,        0, 0, 0, 3);
    vecs[11] = mk(1, 9, 32'h5000, 4, 0, 0,  0, 0, 0,        0, 0, 0, 3);
    vecs[12] = mk(0, 0, 0,        0, 1, 0,  1, 3, 32'h5000, 4, 1, 9, 3);
    vecs[13] = mk(0, 0, 0,        0, 0, 0,  0, 0, 0,        0, 0, 0, 3);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].in_valid, vecs[i].id, vecs[i].addr, vecs[i].len);
      rel_valid = vecs[i].rel_v; rel_tag = vecs[i].rel_t;
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(ar_out_valid), 32'(vecs[i].e_out_valid));
      chk($sformatf("v%0d alloc_valid", i), 32'(alloc_valid), 32'(vecs[i].e_alloc));
      chk($sformatf("v%0d busy_cnt", i), 32'(busy_cnt), 32'(vecs[i].e_busy));
      if (vecs[i].e_out_valid) begin
        chk($sformatf("v%0d out_id", i), 32'(ar_out_id), 32'(vecs[i].e_out_id));
        chk($sformatf("v%0d out_addr", i), ar_out_addr, vecs[i].e_out_addr);
        chk($sformatf("v%0d out_len", i), 32'(ar_out_len), 32'(vecs[i].e_out_len));
      end
      if (vecs[i].e_alloc) begin
        chk($sformatf("v%0d alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].e_out_id));
        chk($sformatf("v%0d alloc_id", i), 32'(alloc_id), 32'(vecs[i].e_alloc_id));
      end
    end
    drive(0, 0, 0, 0); rel_valid = 1'b0;
    lk_tag = 4'd0; #1;
    chk("lk0 id", 32'(lk_id), 5);   chk("lk0 len", 32'(lk_len), 3);
    lk_tag = 4'd1; #1;
    chk("lk1 id", 32'(lk_id), 7);   chk("lk1 len", 32'(lk_len), 2);
    lk_tag = 4'd3; #1;
    chk("lk3 id", 32'(lk_id), 9);   chk("lk3 len", 32'(lk_len), 4);

    // Exhaustion: 16 requests must take tags 0..15 in order.
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    exp_tag = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive(1, 4'(i), 32'h100 * i, 8'(i));
      else drive(0, 0, 0, 0);
      tick();
      if (alloc_valid) begin
        chk("exh alloc_tag", 32'(alloc_tag), 32'(exp_tag));
        chk("exh alloc_id", 32'(alloc_id), 32'(exp_tag % 16));
        exp_tag++;
      end
    end
    chk("exh alloc count", 32'(exp_tag), 16);
    chk("exh busy_cnt", 32'(busy_cnt), 16);
    for (int j = 0; j < 4; j++) begin
      chk("exh in_ready before push", 32'(ar_in_ready), 1);
      drive(1, 4'(10 + j), 32'hA000 + j, 8'(j));
      tick();
      chk("exh no alloc", 32'(alloc_valid), 0);
    end
    drive(0, 0, 0, 0);
    chk("exh fifo full ready", 32'(ar_in_ready), 0);
    repeat (3) begin
      tick();
      chk("exh out_valid idle", 32'(ar_out_valid), 0);
    end

    // Release tag 7: reused one cycle later, never in the release cycle.
    rel_valid = 1'b1; rel_tag = 4'd7;
    tick();
    chk("rel cycle alloc", 32'(alloc_valid), 0);
    chk("rel cycle out_valid", 32'(ar_out_valid), 0);
    chk("rel busy_cnt", 32'(busy_cnt), 15);
    rel_valid = 1'b0; ar_out_ready = 1'b0;
    tick();
    chk("reuse out_valid", 32'(ar_out_valid), 1);
    chk("reuse out_id", 32'(ar_out_id), 7);
    chk("reuse alloc_tag", 32'(alloc_tag), 7);
    chk("reuse alloc_id", 32'(alloc_id), 10);
    chk("reuse busy_cnt", 32'(busy_cnt), 16);
    chk("reuse in_ready", 32'(ar_in_ready), 1);

    // Backpressure: output held for 5 cycles while tags 8..10 free up.
    for (int k = 0; k < 5; k++) begin
      rel_valid = (k < 3); rel_tag = 4'(8 + k);
      tick();
      chk("bp out_valid", 32'(ar_out_valid), 1);
      chk("bp out_id", 32'(ar_out_id), 7);
      chk("bp out_addr", ar_out_addr, 32'hA000);
      chk("bp no alloc", 32'(alloc_valid), 0);
    end
    rel_valid = 1'b0;
    chk("bp busy_cnt", 32'(busy_cnt), 13);
    ar_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp drain out_valid", 32'(ar_out_valid), 1);
      chk("bp drain out_id", 32'(ar_out_id), 32'(8 + k));
      chk("bp drain alloc_id", 32'(alloc_id), 32'(11 + k));
    end
    tick();
    chk("bp final out_valid", 32'(ar_out_valid), 0);
    chk("bp final busy_cnt", 32'(busy_cnt), 16);

    // Error: releasing a free tag is sticky and changes nothing else.
    rel_valid = 1'b1; rel_tag = 4'd3;
    tick();
    chk("err first rel", 32'(err_rel), 0);
    tick();
    chk("err set", 32'(err_rel), 1);
    chk("err busy_cnt", 32'(busy_cnt), 15);
    rel_valid = 1'b0;
    tick();
    chk("err sticky", 32'(err_rel), 1);

    // Async reset with 4 tags busy and 2 requests queued.
    rst = 1'b1; #2; rst = 1'b0;
    chk("rst clears err", 32'(err_rel), 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1, 4'(i + 1), 32'h10 * i, 0); else drive(0, 0, 0, 0);
      tick();
    end
    ar_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(i + 4), 32'h80 + i, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("pre-rst busy_cnt", 32'(busy_cnt), 4);
    chk("pre-rst out_valid", 32'(ar_out_valid), 1);
    chk("pre-rst out_id", 32'(ar_out_id), 3);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(ar_out_valid), 0);
    chk("async rst busy_cnt", 32'(busy_cnt), 0);
    chk("async rst in_ready", 32'(ar_in_ready), 1);
    rst = 1'b0; ar_out_ready = 1'b1;
    drive(1, 4'hE, 32'hBEEF, 8'd1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("post-rst out_valid", 32'(ar_out_valid), 1);
    chk("post-rst out_id", 32'(ar_out_id), 0);
    chk("post-rst alloc_id", 32'(alloc_id), 32'hE);
    chk("post-rst out_addr", ar_out_addr, 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_tag_allocator.md
Name: ar_tag_allocator

Overview:
- Request-side counterpart of the R-channel return path.
- Accepts AR requests from the AXI master and buffers them in a small FIFO.
- Assigns each request a unique ROB tag taken from a free pool, then forwards it to the AXI slave with ID = tag.
- Records each tag's original ID and LEN for the R ordering unit. Tags return to the pool when the ordering unit signals the final R beat has been delivered.

Parameters:
- ID_WIDTH, 4, master-side AXI ID width.
- ADDR_WIDTH, 32, AR address width.
- LEN_WIDTH, 8, AXI burst length field width.
- TAG_WIDTH, 4, slave-side ID width; NUM_TAGS = 2**TAG_WIDTH outstanding bursts.
- DEPTH, 4, input FIFO entries (DEPTH >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ar_in_valid  in  1  AR valid from master.
- ar_in_ready  out  1  AR ready to master.
- ar_in_id  in  ID_WIDTH  master ID.
- ar_in_addr  in  ADDR_WIDTH  address.
- ar_in_len  in  LEN_WIDTH  burst length - 1.
- ar_out_valid  out  1  AR valid to slave.
- ar_out_ready  in  1  AR ready from slave.
- ar_out_id  out  TAG_WIDTH  allocated tag.
- ar_out_addr  out  ADDR_WIDTH  address.
- ar_out_len  out  LEN_WIDTH  length.
- alloc_valid  out  1  one-cycle pulse: tag allocated.
- alloc_tag  out  TAG_WIDTH  tag allocated.
- alloc_id  out  ID_WIDTH  original ID bound to alloc_tag.
- rel_valid  in  1  release strobe from ordering unit.
- rel_tag  in  TAG_WIDTH  tag to release.
- lk_tag  in  TAG_WIDTH  lookup index.
- lk_id  out  ID_WIDTH  original ID of lk_tag (combinational).
- lk_len  out  LEN_WIDTH  LEN of lk_tag (combinational).
- busy_cnt  out  TAG_WIDTH+1  number of tags in use.
- err_rel  out  1  sticky: release of a non-busy tag.

Behaviour:
- Reset (asynchronous):
  - FIFO empty, all tags free, output stage empty.
  - ar_out_valid=0, alloc_valid=0, busy_cnt=0, err_rel=0.
  - ar_in_ready=1 (it equals ~fifo_full).
  - Table contents are not reset. lk_* for a free tag are don't-care.
- Input FIFO:
  - push = ar_in_valid & ar_in_ready.
  - Stores {id, addr, len}, with pointer wrap at DEPTH-1.
  - A simultaneous push and pop while full is not allowed: ready is low when full.
- Allocation:
  - tag_avail = any free tag.
  - free_tag = the lowest-index free tag (priority encode).
  - load = fifo_nonempty & tag_avail & (~ar_out_valid | ar_out_ready).
- On load, at the clock edge:
  - The FIFO head pops into the output register; ar_out_id = free_tag.
  - The busy bit for free_tag is set.
  - table[free_tag] <= {head.id, head.len}.
  - alloc_valid=1 for exactly that following cycle, with alloc_tag and alloc_id.
- Output stage:
  - Holds one request. ar_out_valid stays high and all ar_out_* stay stable until ar_out_ready is sampled high.
  - Back-to-back loads give one request per cycle.
- Latency and ordering:
  - A request accepted at edge k presents ar_out_valid after edge k+1 when a tag is free and the output stage is empty or draining.
  - FIFO order is preserved; a stalled head blocks everything behind it.
- Exhaustion:
  - With no free tag, load=0 and the FIFO keeps accepting until full.
  - ar_in_ready drops only when the FIFO is full.
- Release:
  - rel_valid with a busy rel_tag clears its busy bit at the edge.
  - The freed tag is usable from the next cycle, never in the same cycle.
  - rel_valid with a free tag makes no state change and sets err_rel=1 until reset.
- Simultaneous load and release:
  - Allowed. The released tag is not visible to the same-cycle priority encode.
  - busy_cnt = busy_cnt + load - valid_release, with net 0 when both occur.
- busy_cnt range is 0..NUM_TAGS, which needs the TAG_WIDTH+1 width.
- Reset mid-operation discards all in-flight FIFO and output-stage requests and frees all tags.

Decomposition:
- rob_pkg holds:
  - ar_req_t {id, addr, len}
  - tag_entry_t {id, len}
  - TAG_WIDTH default and NUM_TAGS
- Sub-module tag_free_pool holds:
  - the busy vector
  - the lowest-free priority encoder
  - release and error handling
  - busy_cnt
- The FIFO, output stage and table stay in ar_tag_allocator.

Test Plan:
- Single request:
  - Stimulus: id=5, addr=0x1000, len=3, ar_out_ready=1.
  - Response: ar_out_valid after edge k+1 with ar_out_id=0 and addr/len unchanged; alloc pulse with tag 0 / id 5; lk_tag=0 gives lk_id=5, lk_len=3; busy_cnt=1.
- Tag exhaustion:
  - Stimulus: 16 requests issued, none released, then 4 more requests.
  - Response: tags 0..15 issued in order and busy_cnt=16. The 4 extra requests fill the FIFO, ar_in_ready=0, and ar_out_valid stays 0 after the 16th drains.
- Release and reuse:
  - Stimulus: from the full state, release tag 7.
  - Response: the next request leaves with tag 7 one cycle later, never in the release cycle; busy_cnt returns to 16.
- Backpressure:
  - Stimulus: ar_out_ready=0 for 5 cycles with 3 queued requests.
  - Response: ar_out_* stay stable, no extra allocations occur, and after ready rises the tags are issued back-to-back one per cycle.
- Error:
  - Stimulus: rel_valid with tag 3 while it is free.
  - Response: err_rel=1 and stays high; busy_cnt unchanged.
- Async reset:
  - Stimulus: rst asserted mid-burst with 2 requests queued and 4 tags busy.
  - Response: immediately ar_out_valid=0, busy_cnt=0, ar_in_ready=1; after release, the first request gets tag 0.
